// File: rtl/instr_mem_loader_pkg.sv
// Shared types and sizes for the instruction-memory bootloader.
package instr_mem_loader_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
  localparam int unsigned LEN_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  // An image must hold at least one word and fit in the memory.
  function automatic logic len_ok(input logic [LEN_W-1:0] len,
                                  input logic [LEN_W-1:0] max_len);
    return (len != '0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_word_packer.sv
// Assembles bytes MSB-first into 32-bit words; word_valid pulses the cycle
// after the last byte of a word is taken.
module byte_word_packer
  import instr_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_c,
  output logic              last_c,
  output logic              word_valid
);

  // Only the three most recent bytes are kept; the fourth arrives on byte_in.
  logic [WORD_W-BYTE_W-1:0] shreg;
  logic [BYTE_CNT_W-1:0]    cnt;

  assign word_c = {shreg, byte_in};
  assign last_c = byte_en && (cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      shreg      <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= last_c;
      if (byte_en) begin
        shreg <= word_c[WORD_W-BYTE_W-1:0];
        cnt   <= cnt + BYTE_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream bootloader: writes the instruction memory word by word and holds
// the CPU until the image and its trailing checksum byte have been accepted.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  start_len,
  input  logic              s_valid,
  input  logic [BYTE_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  words_loaded
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH_WORDS);

  state_t             state, state_nx;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   word_idx;
  logic [BYTE_W-1:0]  sum_q;
  logic [BYTE_W-1:0]  sum_nx_c;
  logic [WORD_W-1:0]  word_c;
  logic               word_last_c;
  logic               accept_c;
  logic               idle_like_c;
  logic               load_start_c;
  logic               pack_en_c;

  assign accept_c     = s_valid && s_ready;
  assign idle_like_c  = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign load_start_c = start && idle_like_c && len_ok(start_len, MAX_LEN);
  assign pack_en_c    = accept_c && (state == ST_RECV);
  assign sum_nx_c     = BYTE_W'(sum_q + s_data);
  assign words_loaded = word_idx;

  // mem_we is the packer's registered word_valid, high exactly in WRITE.
  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_start_c),
    .byte_en    (pack_en_c),
    .byte_in    (s_data),
    .word_c     (word_c),
    .last_c     (word_last_c),
    .word_valid (mem_we)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR:
        if (start) state_nx = len_ok(start_len, MAX_LEN) ? ST_RECV : ST_ERR;
      ST_RECV:
        if (word_last_c) state_nx = ST_WRITE;
      ST_WRITE:
        state_nx = (LEN_W'(word_idx + LEN_W'(1)) == len_q) ? ST_CHECK : ST_RECV;
      ST_CHECK:
        if (accept_c) state_nx = (sum_nx_c == '0) ? ST_DONE : ST_ERR;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  // Status outputs are registered copies of the next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      s_ready  <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      state    <= state_nx;
      s_ready  <= (state_nx == ST_RECV) || (state_nx == ST_CHECK);
      done     <= (state_nx == ST_DONE);
      error    <= (state_nx == ST_ERR);
      cpu_hold <= (state_nx != ST_DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      sum_q     <= '0;
      word_idx  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (load_start_c) begin
        len_q    <= start_len;
        sum_q    <= '0;
        word_idx <= '0;
      end
      if (accept_c) sum_q <= sum_nx_c;
      if (word_last_c) begin
        mem_addr  <= ADDR_W'({word_idx, BYTE_CNT_W'(0)});
        mem_wdata <= word_c;
      end
      if (state == ST_WRITE) word_idx <= LEN_W'(word_idx + LEN_W'(1));
    end
  end

endmodule
